// File: rtl/sseg_pkg.sv
// Shared 7-segment definitions: glyph table for hex 0..F, blank pattern, segment bit indices.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Both the encoder and the scan-capture decoder use this table, so the two ends
// of a display loopback cannot disagree about what a glyph looks like.
package sseg_pkg;

  // Bit position of each segment on the 7-bit segment bus.
  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h7B;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Indexed by nibble value: SEG_GLYPH[n] is the pattern that displays n.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
    SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
    SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
    SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
  };

endpackage

// File: rtl/sseg_glyph_dec.sv
// Combinational 7-segment glyph decoder: segment pattern -> {nibble, err, blank}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: seg_in[6:0] segment lines (bit0 = a .. bit6 = g); nibble[3:0] decoded value
//        (0 for blank/unknown); err = unrecognised non-blank pattern; blank = all segments off.
module sseg_glyph_dec
  import sseg_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] nibble,
  output logic       err,
  output logic       blank
);

  logic hit;

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b0;
    blank  = (seg_in == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg_in == SEG_GLYPH[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
    err = !blank && !hit;
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Scan-capture of a multiplexed 7-segment bus: qualifies each digit for stability, decodes it, assembles frames.
// Latency: digit captured on the edge its STABLE_CYCLES-th identical sample is taken; frame_valid rises one edge after the last capture.
// Backpressure: frame held until frame_valid & frame_ready; a frame completing while the held one is unaccepted is dropped and overrun pulses.
// Ports: clk, rst (sync, active high); seg_in[6:0], seg_oe, dig_sel[NDIG-1:0] sampled bus;
//        frame_data[4*NDIG-1:0], frame_err, frame_blank, frame_valid / frame_ready handshake; overrun pulse.
// Optional macro SSEG_DP_EN adds input seg_dp (part of the stability compare) and output frame_dp.
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic                seg_oe,
  input  logic [NDIG-1:0]     dig_sel,
`ifdef SSEG_DP_EN
  input  logic                seg_dp,
  output logic [NDIG-1:0]     frame_dp,
`endif
  output logic [4*NDIG-1:0]   frame_data,
  output logic [NDIG-1:0]     frame_err,
  output logic [NDIG-1:0]     frame_blank,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
`ifdef SSEG_DP_EN
  localparam int KW = NDIG + 8;
`else
  localparam int KW = NDIG + 7;
`endif

  // Sample key used for the "same as last cycle" compare.
  logic [KW-1:0] key;
`ifdef SSEG_DP_EN
  assign key = {dig_sel, seg_dp, seg_in};
`else
  assign key = {dig_sel, seg_in};
`endif

  logic [KW-1:0]     prev_key;
  logic              prev_vld;   // prev_key holds a qualified sample
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              armed, armed_nxt, armed_eff;
  logic              qual, same, capture;
  logic [NDIG-1:0]   mask, mask_nxt;
  logic              complete, complete_nxt;
  logic [4*NDIG-1:0] stg_data;
  logic [NDIG-1:0]   stg_err, stg_blank;
`ifdef SSEG_DP_EN
  logic [NDIG-1:0]   stg_dp;
`endif

  logic [3:0] dec_nibble;
  logic       dec_err, dec_blank;

  sseg_glyph_dec u_dec (
    .seg_in (seg_in),
    .nibble (dec_nibble),
    .err    (dec_err),
    .blank  (dec_blank)
  );

  assign qual = seg_oe && $onehot(dig_sel);
  // A previous unqualified cycle never counts as "same": the dwell restarts.
  assign same = prev_vld && (key == prev_key);

  always_comb begin
    cnt_nxt   = '0;
    armed_eff = 1'b0;
    if (qual) begin
      if (same) begin
        cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        armed_eff = armed;
      end else begin
        cnt_nxt   = CW'(1);
        armed_eff = 1'b1;
      end
    end
    // Disarming on capture makes a long dwell capture only once.
    capture   = armed_eff && (cnt_nxt == CNT_MAX);
    armed_nxt = armed_eff && !capture;
  end

  // A pending completion hands off this edge, so the mask restarts from empty;
  // a capture on that same edge then becomes the first digit of the next frame.
  always_comb begin
    mask_nxt     = (complete ? '0 : mask) | (capture ? dig_sel : '0);
    complete_nxt = capture && (&mask_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_key    <= '0;
      prev_vld    <= 1'b0;
      cnt         <= '0;
      armed       <= 1'b0;
      mask        <= '0;
      complete    <= 1'b0;
      stg_data    <= '0;
      stg_err     <= '0;
      stg_blank   <= '0;
      frame_data  <= '0;
      frame_err   <= '0;
      frame_blank <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
`ifdef SSEG_DP_EN
      stg_dp      <= '0;
      frame_dp    <= '0;
`endif
    end else begin
      prev_key <= key;
      prev_vld <= qual;
      cnt      <= cnt_nxt;
      armed    <= armed_nxt;
      mask     <= mask_nxt;
      complete <= complete_nxt;

      for (int i = 0; i < NDIG; i++) begin
        if (capture && dig_sel[i]) begin
          stg_data[4*i +: 4] <= dec_nibble;
          stg_err[i]         <= dec_err;
          stg_blank[i]       <= dec_blank;
`ifdef SSEG_DP_EN
          stg_dp[i]          <= seg_dp;
`endif
        end
      end

      overrun <= 1'b0;
      if (complete) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= stg_data;
          frame_err   <= stg_err;
          frame_blank <= stg_blank;
`ifdef SSEG_DP_EN
          frame_dp    <= stg_dp;
`endif
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
